timer_counter: RTL and testbench

Programmable 32-bit time-base counter that sits directly upstream of the alarm generator and drives its counter input.
- A prescaler divides clk_i into count ticks.
- The counter advances on each tick and wraps either at a programmable terminal value or at full scale.
- Continuous and one-shot modes; software load supported.
- Outputs tick/wrap pulses and a sticky overflow flag for interrupt/status logic.

---
 rtl/timer_counter.sv | 129 ++++++++++++
 tb/tb_timer_counter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
`default_nettype none
// ============================================================================
// Module   : timer_counter
// Brief    : Prescaled 32-bit time-base counter with terminal/full-scale wrap,
//            one-shot mode, software load and a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module timer_counter #(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cnt_en_i,
  input  logic               oneshot_i,
  input  logic [PRESC_W-1:0] presc_i,
  input  logic               load_i,
  input  logic [CNT_W-1:0]   load_val_i,
  input  logic               wrap_en_i,
  input  logic [CNT_W-1:0]   wrap_val_i,
  input  logic               ovf_clr_i,
  output logic [CNT_W-1:0]   counter_o,
  output logic               tick_o,
  output logic               wrap_o,
  output logic               overflow_o,
  output logic               busy_o
);

  typedef logic [1:0] state_t;
  localparam state_t           C_ST_IDLE = 2'd0;
  localparam state_t           C_ST_RUN  = 2'd1;
  localparam state_t           C_ST_DONE = 2'd2;
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  state_t             r_state_q, w_state_d;
  logic [PRESC_W-1:0] r_presc_q, w_presc_d;
  logic [CNT_W-1:0]   r_count_q, w_count_d;
  logic               r_tick_q, w_tick_d;
  logic               r_wrap_q, w_wrap_d;
  logic               r_ovf_q, w_ovf_d;
  logic               r_busy_q, w_busy_d;

  logic               w_run_active;
  logic               w_presc_hit;
  logic               w_tick_evt;
  logic               w_wrap_evt;
  logic [CNT_W-1:0]   w_term_val;

  // The >= compare lets a lowered divide value take effect immediately.
  assign w_run_active = (r_state_q == C_ST_RUN) && cnt_en_i;
  assign w_presc_hit  = (r_presc_q >= presc_i);
  assign w_tick_evt   = w_run_active && w_presc_hit && !load_i;
  assign w_term_val   = wrap_en_i ? wrap_val_i : C_CNT_MAX;
  assign w_wrap_evt   = w_tick_evt && (r_count_q == w_term_val);

  always_comb begin
    w_state_d = r_state_q;
    case (r_state_q)
      C_ST_IDLE: begin
        if (cnt_en_i) begin
          w_state_d = C_ST_RUN;
        end
      end
      C_ST_RUN: begin
        if (!cnt_en_i) begin
          w_state_d = C_ST_IDLE;
        end else if (w_wrap_evt && oneshot_i) begin
          w_state_d = C_ST_DONE;
        end
      end
      C_ST_DONE: begin
        if (!cnt_en_i) begin
          w_state_d = C_ST_IDLE;
        end else if (load_i) begin
          w_state_d = C_ST_RUN;
        end
      end
      default: w_state_d = C_ST_IDLE;
    endcase
  end

  // Load beats a coincident tick; outside an active RUN cycle the prescaler is cleared.
  always_comb begin
    w_presc_d = '0;
    w_count_d = r_count_q;
    if (load_i) begin
      w_count_d = load_val_i;
    end else if (w_tick_evt) begin
      w_count_d = w_wrap_evt ? '0 : (r_count_q + CNT_W'(1));
    end else if (w_run_active) begin
      w_presc_d = r_presc_q + PRESC_W'(1);
    end
  end

  always_comb begin
    w_tick_d = w_tick_evt;
    w_wrap_d = w_wrap_evt;
    w_ovf_d  = w_wrap_evt | (r_ovf_q & ~ovf_clr_i);
    w_busy_d = (w_state_d == C_ST_RUN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state_q <= C_ST_IDLE;
      r_presc_q <= '0;
      r_count_q <= '0;
      r_tick_q  <= 1'b0;
      r_wrap_q  <= 1'b0;
      r_ovf_q   <= 1'b0;
      r_busy_q  <= 1'b0;
    end else begin
      r_state_q <= w_state_d;
      r_presc_q <= w_presc_d;
      r_count_q <= w_count_d;
      r_tick_q  <= w_tick_d;
      r_wrap_q  <= w_wrap_d;
      r_ovf_q   <= w_ovf_d;
      r_busy_q  <= w_busy_d;
    end
  end

  assign counter_o  = r_count_q;
  assign tick_o     = r_tick_q;
  assign wrap_o     = r_wrap_q;
  assign overflow_o = r_ovf_q;
  assign busy_o     = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_counter
// Brief    : Vector table, directed corner sequences and randomized traffic
//            scored against a cycle-level reference model of timer_counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cnt_en = 1'b0;
  logic        oneshot = 1'b0;
  logic [15:0] presc = '0;
  logic        load = 1'b0;
  logic [31:0] load_val = '0;
  logic        wrap_en = 1'b0;
  logic [31:0] wrap_val = '0;
  logic        ovf_clr = 1'b0;
  logic [31:0] counter;
  logic        tick, wrap, overflow, busy;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  timer_counter #(.CNT_W(32), .PRESC_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .cnt_en_i(cnt_en), .oneshot_i(oneshot),
    .presc_i(presc), .load_i(load), .load_val_i(load_val),
    .wrap_en_i(wrap_en), .wrap_val_i(wrap_val), .ovf_clr_i(ovf_clr),
    .counter_o(counter), .tick_o(tick), .wrap_o(wrap),
    .overflow_o(overflow), .busy_o(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: modes and the divider are tracked with plain integers.
  localparam int M_STOPPED = 0, M_COUNTING = 1, M_FINISHED = 2;
  int          m_mode;
  logic [31:0] m_cnt;
  int unsigned m_div;
  bit          m_tick, m_wrap, m_ovf;

  always @(posedge clk) begin : p_model
    int          mode_n;
    logic [31:0] cnt_n, limit;
    int unsigned div_n;
    bit          tk, wr, ov_n, counting;
    if (rst) begin
      mode_n = M_STOPPED; cnt_n = 0; div_n = 0; tk = 0; wr = 0; ov_n = 0;
    end else begin
      mode_n = m_mode; cnt_n = m_cnt; div_n = 0; tk = 0; wr = 0;
      counting = (m_mode == M_COUNTING) && cnt_en;
      if (load) begin
        cnt_n = load_val;
      end else if (counting) begin
        if (m_div >= 32'(presc)) begin
          tk = 1;
          limit = wrap_en ? wrap_val : 32'hFFFF_FFFF;
          if (m_cnt == limit) begin
            cnt_n = 0; wr = 1;
          end else begin
            cnt_n = m_cnt + 32'd1;
          end
        end else begin
          div_n = m_div + 1;
        end
      end
      if (m_mode == M_STOPPED && cnt_en) mode_n = M_COUNTING;
      else if (m_mode == M_COUNTING && !cnt_en) mode_n = M_STOPPED;
      else if (m_mode == M_COUNTING && wr && oneshot) mode_n = M_FINISHED;
      else if (m_mode == M_FINISHED && !cnt_en) mode_n = M_STOPPED;
      else if (m_mode == M_FINISHED && load) mode_n = M_COUNTING;
      ov_n = wr ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
    end
    m_mode <= mode_n; m_cnt <= cnt_n; m_div <= div_n;
    m_tick <= tk; m_wrap <= wr; m_ovf <= ov_n;
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("model", 64'({counter, tick, wrap, overflow, busy}),
          64'({m_cnt, m_tick, m_wrap, m_ovf, (m_mode == M_COUNTING)}));
    end
  end

  typedef struct {
    logic        cnt_en, oneshot, load, wrap_en, ovf_clr;
    logic [15:0] presc;
    logic [31:0] load_val, wrap_val;
    logic [31:0] exp_cnt;
    logic        exp_tick, exp_wrap, exp_ovf, exp_busy;
  } vec_t;

  function automatic vec_t mk(logic en, logic ld, logic [31:0] lv, logic wen, logic [31:0] wv,
                              logic clr, logic [31:0] ec, logic et, logic ew, logic eo, logic eb);
    vec_t v;
    v.cnt_en = en; v.oneshot = 1'b0; v.presc = 16'd0; v.load = ld; v.load_val = lv;
    v.wrap_en = wen; v.wrap_val = wv; v.ovf_clr = clr;
    v.exp_cnt = ec; v.exp_tick = et; v.exp_wrap = ew; v.exp_ovf = eo; v.exp_busy = eb;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cnt_en = 1'b0; oneshot = 1'b0; presc = '0; load = 1'b0;
    load_val = '0; wrap_en = 1'b0; wrap_val = '0; ovf_clr = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic chk_out(input string name, input logic [31:0] c, input logic t,
                         input logic w, input logic o, input logic b);
    chk({name, ".counter"}, 64'(counter), 64'(c));
    chk({name, ".flags"}, 64'({tick, wrap, overflow, busy}), 64'({t, w, o, b}));
  endtask

  vec_t vecs[$];
  int   nticks;

  initial begin
    // terminal wrap at 5, then load/tick collision, clear and disable
    vecs.push_back(mk(1, 0, 0,   1, 5, 0, 0,   0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0,   1, 5, 0, 1,   1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0,   1, 5, 0, 2,   1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0,   1, 5, 0, 3,   1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0,   1, 5, 0, 4,   1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0,   1, 5, 0, 5,   1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0,   1, 5, 0, 0,   1, 1, 1, 1));
    vecs.push_back(mk(1, 0, 0,   1, 5, 0, 1,   1, 0, 1, 1));
    vecs.push_back(mk(1, 1, 100, 0, 5, 0, 100, 0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0,   0, 5, 0, 101, 1, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0,   0, 5, 1, 102, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,   0, 5, 0, 102, 0, 0, 0, 0));

    do_reset();
    model_on = 1'b1;
    chk_out("reset", 32'd0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cnt_en = vecs[i].cnt_en; oneshot = vecs[i].oneshot; presc = vecs[i].presc;
      load = vecs[i].load; load_val = vecs[i].load_val; wrap_en = vecs[i].wrap_en;
      wrap_val = vecs[i].wrap_val; ovf_clr = vecs[i].ovf_clr;
      cyc();
      chk_out($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_tick,
              vecs[i].exp_wrap, vecs[i].exp_ovf, vecs[i].exp_busy);
    end

    // prescale by 4: one tick every 4th RUN cycle
    do_reset();
    presc = 16'd3; cnt_en = 1'b1;
    cyc();
    nticks = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk($sformatf("presc.tick%0d", i), 64'(tick), 64'((i % 4) == 3));
      if (tick) nticks++;
    end
    chk("presc.count", 64'(nticks), 64'd4);
    chk("presc.counter", 64'(counter), 64'd4);

    // reset mid-run after an overflow, then restart latency
    do_reset();
    presc = 16'd3; wrap_en = 1'b1; wrap_val = 32'd2; cnt_en = 1'b1;
    cyc();
    repeat (20) cyc();
    chk_out("midrun", 32'd2, 1, 0, 1, 1);
    rst = 1'b1;
    cyc();
    chk_out("midrun.rst", 32'd0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("midrun.hold%0d", i), 64'({counter, tick}), 64'({32'd0, 1'b0}));
    end
    cyc();
    chk_out("midrun.first", 32'd1, 1, 0, 0, 1);

    // full-scale wrap with clear collision
    do_reset();
    cnt_en = 1'b1;
    cyc();
    load = 1'b1; load_val = 32'hFFFF_FFFE;
    cyc();
    chk_out("fs.load", 32'hFFFF_FFFE, 0, 0, 0, 1);
    load = 1'b0;
    cyc();
    chk_out("fs.max", 32'hFFFF_FFFF, 1, 0, 0, 1);
    ovf_clr = 1'b1;
    cyc();
    chk_out("fs.wrap_clr", 32'd0, 1, 1, 1, 1);
    cyc();
    chk_out("fs.clr", 32'd1, 1, 0, 0, 1);
    ovf_clr = 1'b0;

    // one-shot then resume via load
    do_reset();
    oneshot = 1'b1; wrap_en = 1'b1; wrap_val = 32'd2; cnt_en = 1'b1;
    cyc();
    cyc(); chk_out("os.1", 32'd1, 1, 0, 0, 1);
    cyc(); chk_out("os.2", 32'd2, 1, 0, 0, 1);
    cyc(); chk_out("os.0", 32'd0, 1, 1, 1, 0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk_out($sformatf("os.done%0d", i), 32'd0, 0, 0, 1, 0);
    end
    load = 1'b1; load_val = 32'd7; wrap_en = 1'b0;
    cyc(); chk_out("os.load", 32'd7, 0, 0, 1, 1);
    load = 1'b0;
    cyc(); chk_out("os.8", 32'd8, 1, 0, 1, 1);
    cyc(); chk_out("os.9", 32'd9, 1, 0, 1, 1);

    // randomized traffic, scored by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      cnt_en   = ($urandom_range(0, 19) != 0);
      oneshot  = ($urandom_range(0, 3) == 0);
      presc    = 16'($urandom_range(0, 3));
      load     = ($urandom_range(0, 15) == 0);
      load_val = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3)))
                                             : 32'($urandom_range(0, 12));
      wrap_en  = ($urandom_range(0, 3) != 0);
      wrap_val = 32'($urandom_range(0, 10));
      ovf_clr  = ($urandom_range(0, 7) == 0);
      cyc();
    end
    rst = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
